// File: rtl/pipe_stage_reg.sv
// Back-pressurable pipeline stage register with a 2-entry skid buffer, valid/ready handshake and flush.
// Optional performance counters (stall_cnt, flush_cnt) are built when PIPE_REG_PERF_EN is defined.
module pipe_stage_reg #(
  parameter int unsigned           DATA_W      = 96,
  parameter int unsigned           CTRL_W      = 24,
  parameter logic [CTRL_W-1:0]     BUBBLE_CTRL = '0,
  parameter int unsigned           CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_REG_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  // Encoding is {main_valid, skid_valid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t            state;
  state_t            stateNxt;
  logic              inReadyQ;
  logic [DATA_W-1:0] mainData;
  logic [CTRL_W-1:0] mainCtrl;
  logic [DATA_W-1:0] skidData;
  logic [CTRL_W-1:0] skidCtrl;
  logic              mainValid;
  logic              skidValid;
  logic              accept;
  logic              emit;
  logic              loadMainIn;
  logic              loadSkidIn;
  logic              moveSkid;

  assign mainValid = state[1];
  assign skidValid = state[0];
  assign accept    = in_valid & inReadyQ;
  assign emit      = mainValid & out_ready;

  always_comb begin
    stateNxt   = state;
    loadMainIn = 1'b0;
    loadSkidIn = 1'b0;
    moveSkid   = 1'b0;
    if (flush) begin
      stateNxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            stateNxt   = ONE;
            loadMainIn = 1'b1;
          end
        end
        ONE: begin
          if (accept && emit) begin
            loadMainIn = 1'b1;
          end else if (accept) begin
            stateNxt   = FULL;
            loadSkidIn = 1'b1;
          end else if (emit) begin
            stateNxt = EMPTY;
          end
        end
        FULL: begin
          if (emit) begin
            stateNxt = ONE;
            moveSkid = 1'b1;
          end
        end
        default: stateNxt = EMPTY;
      endcase
    end
  end

  // in_ready is the registered complement of the next skid_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= EMPTY;
      inReadyQ <= 1'b0;
    end else begin
      state    <= stateNxt;
      inReadyQ <= (stateNxt != FULL);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mainData <= '0;
      mainCtrl <= BUBBLE_CTRL;
      skidData <= '0;
      skidCtrl <= BUBBLE_CTRL;
    end else begin
      if (loadMainIn) begin
        mainData <= in_data;
        mainCtrl <= in_ctrl;
      end else if (moveSkid) begin
        mainData <= skidData;
        mainCtrl <= skidCtrl;
      end
      if (loadSkidIn) begin
        skidData <= in_data;
        skidCtrl <= in_ctrl;
      end
    end
  end

  assign in_ready  = inReadyQ;
  assign out_valid = mainValid;
  assign out_data  = mainData;
  assign out_ctrl  = mainValid ? mainCtrl : BUBBLE_CTRL;

`ifdef PIPE_REG_PERF_EN
  logic [1:0]     squashed;
  logic [CNT_W:0] flushSum;

  // The entry emitted on the flush edge was consumed, so it is not counted as squashed.
  assign squashed = {1'b0, mainValid} + {1'b0, skidValid} - {1'b0, emit};
  assign flushSum = {1'b0, flush_cnt} + (CNT_W+1)'(squashed);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (mainValid && !out_ready && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (flush) begin
        flush_cnt <= flushSum[CNT_W] ? '1 : flushSum[CNT_W-1:0];
      end
    end
  end
`endif

endmodule
